// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline memory port arbiter.
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   localparam logic OWNER_IF   = 1'b0;
   localparam logic OWNER_DATA = 1'b1;

   localparam int MEM_LATENCY_DEFAULT = 2;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter that holds at all-ones; used for stall statistics.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (en && (count != {WIDTH{1'b1}}))
         count <= count + WIDTH'(1);
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-ported memory between IF fetches and MEM-stage accesses.
// Optional stall counters are built when ARB_PERF_CNT_EN is defined.
//
// state | meaning
// IDLE  | free; grants DATA first, then IF, driving the memory strobe this cycle
// BUSY  | read in flight; cnt counts cycles since the accept cycle
// DONE  | owner's Done pulse is high; no grant so a held Req is not re-served
module mem_port_arbiter
   import mips_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              IFReq,
   input  logic [ADDR_W-1:0] IFAddr,
   input  logic              IFKill,
   output logic [DATA_W-1:0] IFRData,
   output logic              IFDone,
   output logic              IFStall,
   input  logic              DataReq,
   input  logic              DataWe,
   input  logic [ADDR_W-1:0] DataAddr,
   input  logic [DATA_W-1:0] DataWData,
   output logic [DATA_W-1:0] DataRData,
   output logic              DataDone,
   output logic              DataStall,
   output logic              MemReq,
   output logic              MemWe,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWData,
`ifdef ARB_PERF_CNT_EN
   output logic [31:0]       IFStallCount,
   output logic [31:0]       DataStallCount,
`endif
   input  logic [DATA_W-1:0] MemRData
);

   localparam int CNT_W = $clog2(MEM_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY);

   arb_state_t       state;
   logic             owner;
   logic             killed;
   logic [CNT_W-1:0] cnt;
   logic             grant_data;
   logic             grant_if;

   // Grants only exist in IDLE and are held off while reset is asserted.
   assign grant_data = !Reset && (state == IDLE) && DataReq;
   assign grant_if   = !Reset && (state == IDLE) && !DataReq && IFReq && !IFKill;

   assign MemReq    = grant_data | grant_if;
   assign MemWe     = grant_data & DataWe;
   assign MemAddr   = grant_data ? DataAddr : (grant_if ? IFAddr : '0);
   assign MemWData  = grant_data ? DataWData : '0;

   assign IFStall   = IFReq & ~IFDone;
   assign DataStall = DataReq & ~DataDone;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         owner     <= OWNER_IF;
         killed    <= 1'b0;
         cnt       <= '0;
         IFRData   <= '0;
         DataRData <= '0;
         IFDone    <= 1'b0;
         DataDone  <= 1'b0;
      end else begin
         IFDone   <= 1'b0;
         DataDone <= 1'b0;
         unique case (state)
            IDLE: begin
               killed <= 1'b0;
               if (grant_data) begin
                  owner <= OWNER_DATA;
                  if (DataWe) begin
                     state    <= DONE;
                     DataDone <= 1'b1;
                  end else begin
                     cnt   <= CNT_W'(1);
                     state <= BUSY;
                  end
               end else if (grant_if) begin
                  owner <= OWNER_IF;
                  cnt   <= CNT_W'(1);
                  state <= BUSY;
               end
            end
            BUSY: begin
               if ((owner == OWNER_IF) && IFKill)
                  killed <= 1'b1;
               if (cnt == CNT_LAST) begin
                  state <= DONE;
                  if (owner == OWNER_DATA) begin
                     DataRData <= MemRData;
                     DataDone  <= 1'b1;
                  end else if (!(killed || IFKill)) begin
                     // a kill landing on the capture cycle still suppresses the fetch
                     IFRData <= MemRData;
                     IFDone  <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if ((owner == OWNER_IF) && IFKill)
                  killed <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ARB_PERF_CNT_EN
   sat_counter #(.WIDTH(32)) u_if_stall_cnt (
      .clk   (Clk),
      .rst   (Reset),
      .en    (IFStall),
      .count (IFStallCount)
   );

   sat_counter #(.WIDTH(32)) u_data_stall_cnt (
      .clk   (Clk),
      .rst   (Reset),
      .en    (DataStall),
      .count (DataStallCount)
   );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (grant time, completion time, memory contents).
module tb_mem_port_arbiter;

   localparam int LAT = 2;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        IFReq, IFKill, DataReq, DataWe;
   logic [31:0] IFAddr, DataAddr, DataWData, MemRData;
   logic [31:0] IFRData, DataRData, MemAddr, MemWData;
   logic        IFDone, IFStall, DataDone, DataStall, MemReq, MemWe;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] IFStallCount, DataStallCount;
`endif

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) dut (
      .Clk(Clk), .Reset(Reset),
      .IFReq(IFReq), .IFAddr(IFAddr), .IFKill(IFKill),
      .IFRData(IFRData), .IFDone(IFDone), .IFStall(IFStall),
      .DataReq(DataReq), .DataWe(DataWe), .DataAddr(DataAddr), .DataWData(DataWData),
      .DataRData(DataRData), .DataDone(DataDone), .DataStall(DataStall),
      .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
`ifdef ARB_PERF_CNT_EN
      .IFStallCount(IFStallCount), .DataStallCount(DataStallCount),
`endif
      .MemRData(MemRData)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // transaction-level model state
   bit          pend_v, pend_if, pend_we, pend_killed;
   int          pend_grant, pend_done, next_free;
   logic [31:0] pend_data, e_if_rdata, e_d_rdata;
   int unsigned e_if_cnt, e_d_cnt;
   logic [31:0] mem [logic [31:0]];
   logic [31:0] rd_due [int];

   // snapshot of DUT outputs for the cycle just completed
   int          s_cyc;
   logic        s_mreq, s_mwe, s_ifd, s_dd, s_ifs, s_ds;
   logic [31:0] s_maddr, s_mwdata, s_ifr, s_dr;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 60)
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : (a ^ 32'h5EED_F00D);
   endfunction

   // One clock cycle: inputs already driven at posedge+1; compare at negedge.
   task automatic step();
      bit          e_ifd, e_dd, gd, gi;
      logic        e_mreq, e_mwe;
      logic [31:0] e_maddr, e_mwdata, a;
      MemRData = rd_due.exists(cyc) ? rd_due[cyc] : $urandom;
      if (rd_due.exists(cyc)) rd_due.delete(cyc);
      @(negedge Clk);
      s_cyc = cyc; s_mreq = MemReq; s_mwe = MemWe; s_maddr = MemAddr; s_mwdata = MemWData;
      s_ifd = IFDone; s_dd = DataDone; s_ifs = IFStall; s_ds = DataStall;
      s_ifr = IFRData; s_dr = DataRData;
      e_ifd = 1'b0; e_dd = 1'b0; gd = 1'b0; gi = 1'b0;
      if (Reset) begin
         pend_v = 1'b0; next_free = 0; e_if_rdata = '0; e_d_rdata = '0;
         rd_due.delete(); e_if_cnt = 0; e_d_cnt = 0;
      end else begin
         e_ifd = pend_v && pend_if && (cyc == pend_done) && !pend_killed;
         e_dd  = pend_v && !pend_if && (cyc == pend_done);
         if (e_ifd) e_if_rdata = pend_data;
         if (e_dd && !pend_we) e_d_rdata = pend_data;
         if (pend_v && pend_if && IFKill && (cyc > pend_grant) && (cyc < pend_done))
            pend_killed = 1'b1;
         gd = (cyc >= next_free) && DataReq;
         gi = (cyc >= next_free) && !DataReq && IFReq && !IFKill;
      end
      e_mreq   = gd || gi;
      e_mwe    = gd && DataWe;
      e_maddr  = gd ? DataAddr : (gi ? IFAddr : 32'h0);
      e_mwdata = gd ? DataWData : 32'h0;
      chk("mem_req", MemReq, e_mreq);
      chk("mem_we", MemWe, e_mwe);
      chk("mem_addr", MemAddr, e_maddr);
      chk("mem_wdata", MemWData, e_mwdata);
      chk("if_done", IFDone, e_ifd);
      chk("data_done", DataDone, e_dd);
      chk("if_rdata", IFRData, e_if_rdata);
      chk("data_rdata", DataRData, e_d_rdata);
      chk("if_stall", IFStall, IFReq && !e_ifd);
      chk("data_stall", DataStall, DataReq && !e_dd);
`ifdef ARB_PERF_CNT_EN
      chk("if_stall_count", IFStallCount, e_if_cnt);
      chk("data_stall_count", DataStallCount, e_d_cnt);
`endif
      if (!Reset) begin
         if (IFReq && !e_ifd) e_if_cnt++;
         if (DataReq && !e_dd) e_d_cnt++;
      end
      if (gd || gi) begin
         pend_v = 1'b1; pend_if = gi; pend_we = gd && DataWe;
         pend_grant = cyc; pend_killed = 1'b0;
         a = gd ? DataAddr : IFAddr;
         if (pend_we) begin
            mem[a] = DataWData; pend_done = cyc + 1; pend_data = '0;
         end else begin
            pend_data = mem_read(a); pend_done = cyc + LAT + 1;
            rd_due[cyc + LAT] = pend_data;
         end
         next_free = pend_done + 1;
      end
      @(posedge Clk); #1;
      cyc++;
   endtask

   task automatic idle_inputs();
      IFReq = 0; IFKill = 0; DataReq = 0; DataWe = 0;
      IFAddr = 0; DataAddr = 0; DataWData = 0;
   endtask

   task automatic reset_dut();
      idle_inputs();
      Reset = 1; step(); step();
      Reset = 0;
   endtask

   task automatic run_to_done(input bit is_if, input int bound);
      int k = 0;
      do begin step(); k++; end while (!(is_if ? s_ifd : s_dd) && (k < bound));
      if (is_if) begin if (!s_ifd) chk("if_done_timeout", s_ifd, 1); end
      else begin if (!s_dd) chk("data_done_timeout", s_dd, 1); end
   endtask

   initial begin
      int t0, dd_at, if_gnt, ifd_at, if_wait, d_wait;
      bit if_act, d_act, ifd_seen;
      idle_inputs(); Reset = 1; MemRData = 0;
      @(posedge Clk); #1;

      // reset state
      reset_dut();
      chk("rst_if_rdata", s_ifr, 0);
      chk("rst_data_rdata", s_dr, 0);
      chk("rst_mem_req", s_mreq, 0);
      chk("rst_dones", {s_ifd, s_dd}, 0);

      // IF read alone
      mem[32'h100] = 32'hDEADBEEF;
      IFReq = 1; IFAddr = 32'h100; t0 = cyc;
      step();
      chk("a_mem_req", s_mreq, 1);
      chk("a_mem_addr", s_maddr, 32'h100);
      chk("a_if_stall", s_ifs, 1);
      run_to_done(1, 12);
      chk("a_done_cycle", s_cyc - t0, 3);
      chk("a_if_rdata", s_ifr, 32'hDEADBEEF);
      IFReq = 0;

      // simultaneous requests, data wins
      reset_dut();
      mem[32'h2000] = 32'hCAFE0001; mem[32'h104] = 32'h11110104;
      DataReq = 1; DataWe = 0; DataAddr = 32'h2000; IFReq = 1; IFAddr = 32'h104;
      t0 = cyc; dd_at = -1; if_gnt = -1; ifd_at = -1;
      for (int k = 0; k < 20 && ifd_at < 0; k++) begin
         step();
         if (s_dd) begin dd_at = s_cyc - t0; DataReq = 0; end
         if (s_mreq && s_maddr == 32'h104 && if_gnt < 0) if_gnt = s_cyc - t0;
         if (s_ifd) begin ifd_at = s_cyc - t0; IFReq = 0; end
      end
      chk("b_data_done_cycle", dd_at, 3);
      chk("b_if_grant_cycle", if_gnt, 4);
      chk("b_if_done_cycle", ifd_at, 7);
      chk("b_data_rdata", s_dr, 32'hCAFE0001);
      chk("b_if_rdata", s_ifr, 32'h11110104);
      step();
`ifdef ARB_PERF_CNT_EN
      chk("b_if_stall_count", IFStallCount, 7);
      chk("b_data_stall_count", DataStallCount, 3);
`endif

      // store, then read it back
      DataReq = 1; DataWe = 1; DataAddr = 32'h2004; DataWData = 32'h12345678;
      step();
      chk("c_mem_we", s_mwe, 1);
      chk("c_mem_addr", s_maddr, 32'h2004);
      chk("c_mem_wdata", s_mwdata, 32'h12345678);
      step();
      chk("c_data_done", s_dd, 1);
      chk("c_rdata_kept", s_dr, 32'hCAFE0001);
      DataWe = 0;
      run_to_done(0, 12);
      chk("c_readback", s_dr, 32'h12345678);
      DataReq = 0;

      // kill a fetch in flight
      IFReq = 1; IFAddr = 32'h108; t0 = cyc; ifd_seen = 0; if_gnt = -1;
      step();
      chk("d_grant", s_mreq, 1);
      IFKill = 1; IFReq = 0;
      step();
      IFKill = 0; IFReq = 1; IFAddr = 32'h10C;
      for (int k = 0; k < 6 && if_gnt < 0; k++) begin
         step();
         if (s_ifd) ifd_seen = 1;
         if (s_mreq && if_gnt < 0) if_gnt = s_cyc - t0;
      end
      chk("d_no_if_done", ifd_seen, 0);
      chk("d_if_rdata_kept", s_ifr, 32'h11110104);
      chk("d_regrant_cycle", if_gnt, 4);
      run_to_done(1, 12);
      IFReq = 0;

      // reset in the middle of a read
      IFReq = 1; IFAddr = 32'h110;
      step();
      Reset = 1; IFReq = 0;
      step();
      chk("e_mem_req", s_mreq, 0);
      chk("e_dones", {s_ifd, s_dd}, 0);
      chk("e_rdata", {s_ifr, s_dr}, 0);
      chk("e_stalls", {s_ifs, s_ds}, 0);
      step();
      Reset = 0; IFReq = 1; IFAddr = 32'h114;
      step();
      chk("e_first_grant", s_mreq, 1);
      chk("e_first_addr", s_maddr, 32'h114);
      run_to_done(1, 12);
      IFReq = 0;

      // randomized traffic
      if_act = 0; d_act = 0; if_wait = 0; d_wait = 0;
      for (int n = 0; n < 3000; n++) begin
         if (if_act && (s_ifd || IFKill)) if_act = 0;
         if (d_act && s_dd) d_act = 0;
         Reset = ($urandom_range(499) == 0);
         if (Reset) begin if_act = 0; d_act = 0; end
         IFKill = !Reset && ($urandom_range(15) == 0);
         if (!Reset && !if_act && $urandom_range(2) == 0) begin
            if_act = 1; IFAddr = 32'($urandom_range(255)) << 2;
         end
         if (!Reset && !d_act && $urandom_range(3) == 0) begin
            d_act = 1; DataWe = 1'($urandom_range(1));
            DataAddr = 32'h2000 + (32'($urandom_range(3)) << 2);
            DataWData = $urandom;
         end
         IFReq = if_act; DataReq = d_act;
         step();
         if_wait = s_ifs ? if_wait + 1 : 0;
         d_wait  = s_ds ? d_wait + 1 : 0;
         if (if_wait > 60) begin chk("if_stall_bound", if_wait, 60); if_wait = 0; end
         if (d_wait > 12) begin chk("data_stall_bound", d_wait, 12); d_wait = 0; end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
